qmux_tag: RTL

- Merges two queue streams into one tagged queue stream of layout {eot, ctrl, data}. This is the producer side of the tagged-union queue format that per-field filters consume.
- Granularity is whole transactions: once an input is granted, it keeps the output until its transaction-closing eot has been forwarded.
- Sits in front of a tagged queue link. Applying a field filter with SEL=k to this block's output recovers input k unchanged.

---
 rtl/qmux_tag.sv | 133 +++++++++++++
 1 files changed

// File: rtl/qmux_tag.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qmux_tag : two-input transaction-granular merge onto a tagged queue      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qmux_tag #(
  parameter int W_DIN   = 16,
  parameter int LVL     = 1,
  parameter int W_CTRL  = 1,
  parameter int ARB_LVL = LVL
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            din0_valid,
  output logic                            din0_ready,
  input  logic [LVL+W_DIN-1:0]            din0_data,
  input  logic                            din1_valid,
  output logic                            din1_ready,
  input  logic [LVL+W_DIN-1:0]            din1_data,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [LVL+W_CTRL+W_DIN-1:0]     dout_data
);

  localparam int W_OUT = LVL + W_CTRL + W_DIN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             reg_valid_q, reg_valid_d;
  logic [W_OUT-1:0] reg_data_q, reg_data_d;

  logic             sel0, sel1, can_load, acc0, acc1;
  logic             end0, end1;
  logic [LVL-1:0]   eot0, eot1;
  logic [W_CTRL-1:0] ctrl_tag;

  assign eot0 = din0_data[LVL+W_DIN-1:W_DIN];
  assign eot1 = din1_data[LVL+W_DIN-1:W_DIN];

  // A lock ends on a beat whose low ARB_LVL eot bits are all set.
  generate
    if (ARB_LVL == 0) begin : g_arb_every
      assign end0 = 1'b1;
      assign end1 = 1'b1;
    end else begin : g_arb_eot
      assign end0 = &eot0[ARB_LVL-1:0];
      assign end1 = &eot1[ARB_LVL-1:0];
    end
  endgenerate

  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (din0_valid && din1_valid) begin
          sel0 = last_grant_q;
          sel1 = !last_grant_q;
        end else begin
          sel0 = din0_valid;
          sel1 = din1_valid;
        end
      end
      LOCK0:   sel0 = 1'b1;
      LOCK1:   sel1 = 1'b1;
      default: ;
    endcase
  end

  assign can_load   = !reg_valid_q || dout_ready;
  assign din0_ready = sel0 && can_load && !rst;
  assign din1_ready = sel1 && can_load && !rst;
  assign acc0       = din0_ready && din0_valid;
  assign acc1       = din1_ready && din1_valid;

  always_comb begin
    ctrl_tag    = '0;
    ctrl_tag[0] = acc1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    reg_valid_d  = reg_valid_q;
    reg_data_d   = reg_data_q;
    if (acc0) begin
      reg_valid_d = 1'b1;
      reg_data_d  = {eot0, ctrl_tag, din0_data[W_DIN-1:0]};
      if (end0) begin
        state_d      = IDLE;
        last_grant_d = 1'b0;
      end else begin
        state_d = LOCK0;
      end
    end else if (acc1) begin
      reg_valid_d = 1'b1;
      reg_data_d  = {eot1, ctrl_tag, din1_data[W_DIN-1:0]};
      if (end1) begin
        state_d      = IDLE;
        last_grant_d = 1'b1;
      end else begin
        state_d = LOCK1;
      end
    end else if (reg_valid_q && dout_ready) begin
      reg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      reg_valid_q  <= 1'b0;
      reg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      reg_valid_q  <= reg_valid_d;
      reg_data_q   <= reg_data_d;
    end
  end

  assign dout_valid = reg_valid_q;
  assign dout_data  = reg_data_q;

endmodule
`default_nettype wire
